// File: rtl/comparator32_pkg.sv
// ---------------------------------------------------------------------------
// comparator32_pkg
//
// Purpose:
//   Shared types, constants and the tree merge helper for the registered
//   magnitude comparator (comparator32) and its nibble cell (cmp_nibble).
//
// Contents:
//   CMP_WIDTH     - default operand width of the comparator
//   NIB_W         - width of one compare cell
//   cmp_flags_t   - registered result {gt, lt, eq}, exactly one bit set
//   CMP_FLAGS_RST - result presented while in reset (equal)
//   cmp_pair_t    - partial result {gt, eq} carried through the merge tree
//   cmp_merge()   - combines a more significant and a less significant pair
//
// Configuration macro used by the design files: COMPARATOR32_SIGNED_EN
// ---------------------------------------------------------------------------
package comparator32_pkg;

  localparam int CMP_WIDTH = 32;
  localparam int NIB_W     = 4;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_flags_t;

  // Reset reports "equal" so the one-hot property holds even in reset.
  localparam cmp_flags_t CMP_FLAGS_RST = 3'b001;

  typedef struct packed {
    logic gt;
    logic eq;
  } cmp_pair_t;

  // The more significant half decides unless it is equal, in which case the
  // less significant half decides. Equality needs both halves equal.
  function automatic cmp_pair_t cmp_merge(cmp_pair_t hi, cmp_pair_t lo);
    cmp_pair_t res;
    res.gt = hi.gt | (hi.eq & lo.gt);
    res.eq = hi.eq & lo.eq;
    return res;
  endfunction

endpackage

// File: rtl/comparator32_nibble.sv
// ---------------------------------------------------------------------------
// cmp_nibble
//
// Purpose:
//   Purely combinational 4-bit compare cell, the leaf of the comparator tree.
//   Produces a local greater-than / equal pair for one nibble of A and B.
//
// Ports:
//   a_i        [3:0] in  - nibble of operand A
//   b_i        [3:0] in  - nibble of operand B
//   msb_signed       in  - 1: treat bit 3 as a two's-complement sign bit
//                          (only ever set on the most significant cell)
//   gt_o             out - A nibble > B nibble
//   eq_o             out - A nibble == B nibble
//
// Configuration: none locally; the top ties msb_signed to 0 unless built
// with COMPARATOR32_SIGNED_EN.
// ---------------------------------------------------------------------------
module cmp_nibble
  import comparator32_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             msb_signed,
  output logic             gt_o,
  output logic             eq_o
);

  logic [NIB_W-1:0] a_eff;
  logic [NIB_W-1:0] b_eff;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so the same unsigned compare serves both modes.
  // Equality is unaffected because both sides flip together.
  always_comb begin
    a_eff = a_i;
    b_eff = b_i;
    a_eff[NIB_W-1] = a_i[NIB_W-1] ^ msb_signed;
    b_eff[NIB_W-1] = b_i[NIB_W-1] ^ msb_signed;
    gt_o = (a_eff > b_eff);
    eq_o = (a_i == b_i);
  end

endmodule

// File: rtl/comparator32.sv
// ---------------------------------------------------------------------------
// comparator32
//
// Purpose:
//   Registered WIDTH-bit magnitude comparator. Operands are split into
//   nibbles, each compared by a cmp_nibble cell; the per-nibble (gt, eq)
//   pairs are merged pairwise, most significant side dominant, in a
//   log2(WIDTH/4)-deep tree, and the root result is registered once.
//   Latency is one cycle; a new operand pair is accepted every cycle.
//
// Parameters:
//   WIDTH - operand width, multiple of 4 in 4..64 (default 32)
//
// Ports:
//   clk            in  - rising-edge clock
//   rst            in  - synchronous active-high reset; result forced to eq
//   a_i  [WIDTH-1:0] in  - operand A
//   b_i  [WIDTH-1:0] in  - operand B
//   signed_i       in  - two's-complement compare select
//                        (only present with COMPARATOR32_SIGNED_EN)
//   gt_o           out - registered A > B
//   lt_o           out - registered A < B
//   eq_o           out - registered A == B
//
// Configuration macro: COMPARATOR32_SIGNED_EN
//   undefined - unsigned compare only, no signed_i port
//   defined   - signed_i selects two's-complement order via the MSB cell
// ---------------------------------------------------------------------------
module comparator32
  import comparator32_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef COMPARATOR32_SIGNED_EN
  input  logic             signed_i,
`endif
  output logic             gt_o,
  output logic             lt_o,
  output logic             eq_o
);

  localparam int NIBS   = WIDTH / NIB_W;
  localparam int LEVELS = (NIBS > 1) ? $clog2(NIBS) : 0;

  // Number of live nodes at a given tree level; an odd node at the end of a
  // level is passed straight up to the next one.
  function automatic int level_count(int lvl);
    int c;
    c = NIBS;
    for (int k = 0; k < lvl; k++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

  logic       signed_sel;
  logic [NIBS-1:0] nib_gt;
  logic [NIBS-1:0] nib_eq;
  cmp_pair_t  tree [LEVELS+1][NIBS];
  cmp_pair_t  root;
  cmp_flags_t flags_d;
  cmp_flags_t flags_q;

  // The sign select feeds the tree combinationally, so it is captured on the
  // same edge as the operands it applies to.
`ifdef COMPARATOR32_SIGNED_EN
  assign signed_sel = signed_i;
`else
  assign signed_sel = 1'b0;
`endif

  // Leaf row: one cell per nibble, index 0 is the least significant nibble.
  // Only the most significant cell ever sees the sign select.
  for (genvar n = 0; n < NIBS; n++) begin : g_nib
    if (n == NIBS - 1) begin : g_msb
      cmp_nibble u_cell (
        .a_i        (a_i[n*NIB_W +: NIB_W]),
        .b_i        (b_i[n*NIB_W +: NIB_W]),
        .msb_signed (signed_sel),
        .gt_o       (nib_gt[n]),
        .eq_o       (nib_eq[n])
      );
    end else begin : g_low
      cmp_nibble u_cell (
        .a_i        (a_i[n*NIB_W +: NIB_W]),
        .b_i        (b_i[n*NIB_W +: NIB_W]),
        .msb_signed (1'b0),
        .gt_o       (nib_gt[n]),
        .eq_o       (nib_eq[n])
      );
    end
    assign tree[0][n] = {nib_gt[n], nib_eq[n]};
  end

  // Merge levels: node j of the next level combines nodes 2j+1 (more
  // significant) and 2j of this level. Slots beyond the live node count are
  // tied off so every array element has a driver.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    for (genvar j = 0; j < NIBS; j++) begin : g_node
      if (2 * j + 1 < level_count(l)) begin : g_merge
        assign tree[l+1][j] = cmp_merge(tree[l][2*j+1], tree[l][2*j]);
      end else if (2 * j < level_count(l)) begin : g_pass
        assign tree[l+1][j] = tree[l][2*j];
      end else begin : g_tie
        assign tree[l+1][j] = '0;
      end
    end
  end

  assign root = tree[LEVELS][0];

  // Less-than is not carried through the tree; it is whatever is left once
  // greater-than and equal are both ruled out, which keeps the flags one-hot.
  always_comb begin
    flags_d    = CMP_FLAGS_RST;
    flags_d.gt = root.gt;
    flags_d.eq = root.eq;
    flags_d.lt = ~root.gt & ~root.eq;
  end

  // Single output register stage. Reset wins over whatever the tree is
  // presenting on that edge, so a pending result is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= CMP_FLAGS_RST;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign gt_o = flags_q.gt;
  assign lt_o = flags_q.lt;
  assign eq_o = flags_q.eq;

endmodule

// File: tb/tb_comparator32.sv
// ---------------------------------------------------------------------------
// tb_comparator32
//
// Self-checking bench for comparator32 (WIDTH = 32). Directed vectors come
// from a table of hand-worked expectations; random traffic is compared
// against an arithmetic reference model. Signed vectors are exercised when
// built with COMPARATOR32_SIGNED_EN.
// ---------------------------------------------------------------------------
module tb_comparator32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         signedSel;
  logic         gt_o;
  logic         lt_o;
  logic         eq_o;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    logic         r;
    logic [2:0]   exp;
  } vec_t;

  vec_t vecs[$];

  comparator32 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_i      (a_i),
    .b_i      (b_i),
`ifdef COMPARATOR32_SIGNED_EN
    .signed_i (signedSel),
`endif
    .gt_o     (gt_o),
    .lt_o     (lt_o),
    .eq_o     (eq_o)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Safety net so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: compare the operands as plain integers, sign-extended when a
  // signed compare is requested. Result packed as {gt, lt, eq}.
  function automatic logic [2:0] refCompare(logic [W-1:0] a, logic [W-1:0] b,
                                            logic sgn, logic r);
    longint sa;
    longint sb;
    if (r) return 3'b001;
`ifdef COMPARATOR32_SIGNED_EN
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
`else
    sa = longint'(a) + longint'(sgn & 1'b0);
    sb = longint'(b);
`endif
    return {sa > sb, sa < sb, sa == sb};
  endfunction

  // Drive one operand pair away from the active edge, then let it be
  // captured and settle just after the edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sgn, input logic r);
    @(negedge clk);
    a_i       = a;
    b_i       = b;
    signedSel = sgn;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] exp);
    logic [2:0] act;
    act = {gt_o, lt_o, eq_o};
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got {gt,lt,eq}=%b expected %b (a=%h b=%h)",
               name, act, exp, a_i, b_i);
    end
  endtask

  task automatic checkOneHot(input string name);
    nCompared++;
    if ($countones({gt_o, lt_o, eq_o}) != 1) begin
      nMismatched++;
      $display("[TB] FAIL %s one-hot: got {gt,lt,eq}=%b expected exactly one bit",
               name, {gt_o, lt_o, eq_o});
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic         rr;
    int           mode;
    int           nib;

    rst       = 1'b1;
    a_i       = '0;
    b_i       = '0;
    signedSel = 1'b0;

    // Directed table: reset, release, small values, extremes, tree priority.
    vecs.push_back('{32'h12345678, 32'h00000000, 1'b0, 1'b1, 3'b001});
    vecs.push_back('{32'h12345678, 32'h00000000, 1'b0, 1'b0, 3'b100});
    vecs.push_back('{32'h00000000, 32'h00000000, 1'b0, 1'b0, 3'b001});
    vecs.push_back('{32'h00000000, 32'h00000001, 1'b0, 1'b0, 3'b010});
    vecs.push_back('{32'h00000001, 32'h00000000, 1'b0, 1'b0, 3'b100});
    vecs.push_back('{32'h00000001, 32'h00000001, 1'b0, 1'b0, 3'b001});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 3'b001});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 3'b100});
    vecs.push_back('{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b0, 3'b010});
    vecs.push_back('{32'h77777777, 32'h55555555, 1'b0, 1'b0, 3'b100});
    vecs.push_back('{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 3'b100});
    vecs.push_back('{32'h00000010, 32'h0000000F, 1'b0, 1'b0, 3'b100});
    vecs.push_back('{32'h0F000000, 32'h00FFFFFF, 1'b0, 1'b0, 3'b100});
    vecs.push_back('{32'h00FFFFFF, 32'h0F000000, 1'b0, 1'b0, 3'b010});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 3'b100});
`ifdef COMPARATOR32_SIGNED_EN
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 3'b010});
    vecs.push_back('{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 3'b010});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b1, 1'b0, 3'b001});
    vecs.push_back('{32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 3'b100});
    vecs.push_back('{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, 3'b010});
`endif

    $display("[TB] directed table: %0d vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].r);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      checkOneHot($sformatf("vec%0d", i));
    end

    // Latency: the new pair must not show before its capturing edge.
    applyStimulus(32'd3, 32'd9, 1'b0, 1'b0);
    checkOutput("lat_first", 3'b010);
    @(negedge clk);
    a_i = 32'd9;
    b_i = 32'd3;
    #1;
    checkOutput("lat_hold", 3'b010);
    @(posedge clk);
    #1;
    checkOutput("lat_next", 3'b100);

    // Mid-stream reset discards the pending result, then recovery.
    applyStimulus(32'd9, 32'd3, 1'b0, 1'b1);
    checkOutput("midrst_hold", 3'b001);
    applyStimulus(32'd2, 32'd7, 1'b0, 1'b0);
    checkOutput("midrst_release", 3'b010);

    // Back-to-back pairs with reset asserted in the middle of the stream.
    for (int i = 0; i < 50; i++) begin
      ra = $urandom;
      rb = (i % 5 == 0) ? ra : $urandom;
      rs = 1'($urandom_range(0, 1));
      rr = (i == 20 || i == 21 || i == 35);
      applyStimulus(ra, rb, rs, rr);
      checkOutput($sformatf("b2b%0d", i), refCompare(ra, rb, rs, rr));
      checkOneHot($sformatf("b2b%0d", i));
    end

    // Random traffic, biased towards equal and near-equal operands.
    for (int i = 0; i < 10000; i++) begin
      ra   = $urandom;
      mode = $urandom_range(0, 3);
      case (mode)
        0: rb = $urandom;
        1: rb = ra;
        2: rb = ra ^ (32'd1 << $urandom_range(0, W - 1));
        default: begin
          nib = $urandom_range(0, W / 4 - 1);
          rb  = ra;
          rb[nib*4 +: 4] = 4'($urandom);
        end
      endcase
      rs = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 199) == 0);
      applyStimulus(ra, rb, rs, rr);
      checkOutput($sformatf("rnd%0d", i), refCompare(ra, rb, rs, rr));
      checkOneHot($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
